// File: rtl/u_counter_pkg.sv
// Shared types and constants for the counter sequencer.
// Optional build macro used by the sequencer: PRIME_TALLY_EN.
package u_counter_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int HCW_DEF   = 4;

  localparam logic ASSERT_N   = 1'b0;
  localparam logic DEASSERT_N = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    LOAD   = 3'd2,
    SETTLE = 3'd3,
    RUN    = 3'd4,
    HOLD   = 3'd5,
    RET    = 3'd6,
    DONE   = 3'd7
  } state_e;

endpackage

// File: rtl/u_hold_timer.sv
// Loadable down-counter timing the hold at target.
// last_o flags the final hold cycle (count of 1).
module u_hold_timer
  import u_counter_pkg::*;
#(
  parameter int HCW = HCW_DEF
) (
  input  logic           clkb,
  input  logic           rstb,
  input  logic           load_i,
  input  logic           en_i,
  input  logic [HCW-1:0] val_i,
  output logic           last_o
);

  logic [HCW-1:0] cnt_q;
  logic [HCW-1:0] cnt_d;

  // next count: load wins, otherwise step down to zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // count register, falling-edge like the counter
  always_ff @(negedge clkb or negedge rstb) begin
    if (!rstb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == {{(HCW-1){1'b0}}, 1'b1});

endmodule

// File: rtl/u_counter_sequencer.sv
// Drives the up/down counter through clear, load, excursion, hold, return.
// Build macro PRIME_TALLY_EN enables the prime_cnt tally of pn_fb.
module u_counter_sequencer
  import u_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int HCW   = HCW_DEF
) (
  input  logic             clkb,
  input  logic             rstb,
  input  logic             startb,
  input  logic             abortb,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] target,
  input  logic [HCW-1:0]   hold_cycles,
  input  logic [WIDTH-1:0] q_fb,
  input  logic             pn_fb,
  output logic             clrb,
  output logic             ldb,
  output logic             hdb,
  output logic             upb,
  output logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   prime_cnt
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sv_q, tg_q;
  logic [HCW-1:0]   hc_q;
  logic             ht_load, ht_en, ht_last;
  logic             abort;
  logic [WIDTH-1:0] q_up, q_dn;

  assign abort = (abortb == ASSERT_N) && (state_q != IDLE);
  assign q_up  = q_fb + 1'b1;
  assign q_dn  = q_fb - 1'b1;

  u_hold_timer #(.HCW(HCW)) u_ht (
    .clkb   (clkb),
    .rstb   (rstb),
    .load_i (ht_load),
    .en_i   (ht_en),
    .val_i  (hc_q),
    .last_o (ht_last)
  );

  // next state and counter controls; abort forces idle controls
  always_comb begin
    state_d = state_q;
    clrb    = DEASSERT_N;
    ldb     = DEASSERT_N;
    hdb     = 1'b0;
    upb     = 1'b1;
    d       = '0;
    done    = 1'b0;
    ht_load = 1'b0;
    ht_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (startb == ASSERT_N) state_d = CLR;
      end
      CLR: begin
        clrb    = ASSERT_N;
        state_d = LOAD;
      end
      LOAD: begin
        ldb     = ASSERT_N;
        d       = sv_q;
        state_d = SETTLE;
      end
      SETTLE: begin
        state_d = RUN;
      end
      RUN: begin
        if (q_fb != tg_q) begin
          hdb = 1'b1;
          upb = (q_fb < tg_q) ? 1'b0 : 1'b1;
        end else if (hc_q != '0) begin
          ht_load = 1'b1;
          state_d = HOLD;
        end else begin
          state_d = (q_fb == sv_q) ? DONE : RET;
        end
      end
      HOLD: begin
        ht_en = 1'b1;
        if (ht_last) begin
          state_d = (q_fb == sv_q) ? DONE : RET;
        end
      end
      // finish on the edge that lands on start_val,
      // so the return leg needs no extra compare cycle
      RET: begin
        if (q_fb != sv_q) begin
          hdb = 1'b1;
          upb = (q_fb < sv_q) ? 1'b0 : 1'b1;
          if ((upb ? q_dn : q_up) == sv_q) state_d = DONE;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
    endcase
    if (abort) begin
      state_d = IDLE;
      clrb    = DEASSERT_N;
      ldb     = DEASSERT_N;
      hdb     = 1'b0;
      upb     = 1'b1;
      d       = '0;
      done    = 1'b0;
      ht_load = 1'b0;
      ht_en   = 1'b0;
    end
  end

  // state register
  always_ff @(negedge clkb or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // operands captured once per start
  always_ff @(negedge clkb or negedge rstb) begin
    if (!rstb) begin
      sv_q <= '0;
      tg_q <= '0;
      hc_q <= '0;
    end else if ((state_q == IDLE) && (startb == ASSERT_N)) begin
      sv_q <= start_val;
      tg_q <= target;
      hc_q <= hold_cycles;
    end
  end

  assign busy = (state_q != IDLE);

`ifdef PRIME_TALLY_EN
  logic [WIDTH:0] prime_q;
  logic           tally;

  assign tally = pn_fb && (prime_q != '1) &&
                 ((state_q == RUN) || (state_q == HOLD) ||
                  (state_q == RET));

  // saturating tally of prime counter values seen
  always_ff @(negedge clkb or negedge rstb) begin
    if (!rstb) begin
      prime_q <= '0;
    end else if (!abort) begin
      if (state_q == CLR) begin
        prime_q <= '0;
      end else if (tally) begin
        prime_q <= prime_q + 1'b1;
      end
    end
  end

  assign prime_cnt = prime_q;
`else
  logic unused_pn;
  assign unused_pn = pn_fb;
  assign prime_cnt = '0;
`endif

endmodule
